// File: rtl/if_stage.sv
// Instruction-fetch stage feeding the ID decoder.
// Owns the PC and keeps at most one request outstanding to a variable-latency
// instruction ROM. Each fetched word is registered into ID as {pc, inst}. An empty
// slot is a bubble with inst = 0, which decodes as a NOP. A one-entry hold buffer
// absorbs a response that arrives while ID is stalled. A redirect replaces the PC
// and flushes the buffered or in-flight fetch.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        rom_ce_o,
   output logic [31:0] rom_addr_o,
   input  logic        rom_rdy_i,
   input  logic [31:0] rom_data_i,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o,
   output logic        valid_o
);

   // BOOT idles the ROM for one cycle after reset.
   // DRAIN waits out a request that a redirect orphaned.
   localparam logic [1:0] BOOT  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;
   localparam logic [1:0] DRAIN = 2'd3;

   logic [1:0]  state, state_n;
   logic [31:0] pc, pc_n;
   logic [31:0] rom_addr_q, rom_addr_n;
   logic        rom_ce_q, rom_ce_n;
   logic [31:0] pc_q, pc_q_n;
   logic [31:0] inst_q, inst_q_n;
   logic        valid_q, valid_q_n;
   logic [31:0] hold_pc, hold_pc_n;
   logic [31:0] hold_inst, hold_inst_n;
   logic        resp;
   logic [31:0] pc_inc;

   assign rom_ce_o   = rom_ce_q;
   assign rom_addr_o = rom_addr_q;
   assign pc_o       = pc_q;
   assign inst_o     = inst_q;
   assign valid_o    = valid_q;

   // A response only counts while a request is actually on the bus.
   assign resp   = rom_ce_q & rom_rdy_i;
   assign pc_inc = pc + PC_STEP;

   // Next-state logic.
   // A redirect has priority over stall and over any response arriving in the same
   // cycle. The ROM address is frozen while draining an orphaned request, so the ROM
   // never sees its address change before it answers.
   always_comb begin
      state_n     = state;
      pc_n        = pc;
      pc_q_n      = pc_q;
      inst_q_n    = inst_q;
      valid_q_n   = valid_q;
      hold_pc_n   = hold_pc;
      hold_inst_n = hold_inst;

      if (redirect_i) begin
         pc_n        = {redirect_pc_i[31:2], 2'b00};
         hold_pc_n   = 32'h0;
         hold_inst_n = 32'h0;
         pc_q_n      = 32'h0;
         inst_q_n    = 32'h0;
         valid_q_n   = 1'b0;
         if ((state == FETCH || state == DRAIN) && rom_ce_q && !rom_rdy_i)
            state_n = DRAIN;
         else
            state_n = FETCH;
      end else begin
         case (state)
            BOOT: begin
               state_n = FETCH;
            end
            FETCH: begin
               if (resp) begin
                  pc_n = pc_inc;
                  if (!stall_i) begin
                     pc_q_n    = pc;
                     inst_q_n  = rom_data_i;
                     valid_q_n = 1'b1;
                  end else begin
                     hold_pc_n   = pc;
                     hold_inst_n = rom_data_i;
                     state_n     = HOLD;
                  end
               end else if (!stall_i) begin
                  pc_q_n    = 32'h0;
                  inst_q_n  = 32'h0;
                  valid_q_n = 1'b0;
               end
            end
            HOLD: begin
               if (!stall_i) begin
                  pc_q_n    = hold_pc;
                  inst_q_n  = hold_inst;
                  valid_q_n = 1'b1;
                  state_n   = FETCH;
               end
            end
            DRAIN: begin
               if (!stall_i) begin
                  pc_q_n    = 32'h0;
                  inst_q_n  = 32'h0;
                  valid_q_n = 1'b0;
               end
               if (resp)
                  state_n = FETCH;
            end
            default: begin
               state_n = BOOT;
            end
         endcase
      end

      rom_ce_n   = (state_n == FETCH) || (state_n == DRAIN);
      rom_addr_n = (state_n == DRAIN) ? rom_addr_q : pc_n;
   end

   // State, PC, ROM request and ID-facing registers. Reset is synchronous.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= BOOT;
         pc         <= RESET_PC;
         rom_addr_q <= RESET_PC;
         rom_ce_q   <= 1'b0;
         pc_q       <= 32'h0;
         inst_q     <= 32'h0;
         valid_q    <= 1'b0;
         hold_pc    <= 32'h0;
         hold_inst  <= 32'h0;
      end else begin
         state      <= state_n;
         pc         <= pc_n;
         rom_addr_q <= rom_addr_n;
         rom_ce_q   <= rom_ce_n;
         pc_q       <= pc_q_n;
         inst_q     <= inst_q_n;
         valid_q    <= valid_q_n;
         hold_pc    <= hold_pc_n;
         hold_inst  <= hold_inst_n;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage.
// The ROM answers with a word derived from the address it is given. Every expected
// value below is worked out by hand from the sequence of steps.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        rom_ce;
   logic [31:0] rom_addr;
   logic        rom_rdy;
   logic [31:0] rom_data;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic        valid_o;

   int checks = 0;
   int errors = 0;

   if_stage dut (
      .clk          (clk),
      .rst          (rst),
      .stall_i      (stall),
      .redirect_i   (redirect),
      .redirect_pc_i(redirect_pc),
      .rom_ce_o     (rom_ce),
      .rom_addr_o   (rom_addr),
      .rom_rdy_i    (rom_rdy),
      .rom_data_i   (rom_data),
      .pc_o         (pc_o),
      .inst_o       (inst_o),
      .valid_o      (valid_o)
   );

   always #5 clk = ~clk;

   // ROM contents: each word is the address with a marker in the top bits.
   assign rom_data = 32'h2000_0000 | rom_addr;

   function automatic logic [31:0] word(input logic [31:0] a);
      return 32'h2000_0000 | a;
   endfunction

   task automatic applyStimulus(input logic r, input logic s, input logic rd,
                                input logic [31:0] rpc, input logic rdy);
      rst         = r;
      stall       = s;
      redirect    = rd;
      redirect_pc = rpc;
      rom_rdy     = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkSlot(input string tag, input logic [31:0] p, input logic v);
      checkOutput({tag, ".pc"}, pc_o, v ? p : 32'h0);
      checkOutput({tag, ".inst"}, inst_o, v ? word(p) : 32'h0);
      checkOutput({tag, ".valid"}, {31'h0, valid_o}, {31'h0, v});
   endtask

   initial begin
      $display("[TB] if_stage directed run");

      // Reset
      applyStimulus(1, 0, 0, 0, 1);
      applyStimulus(1, 0, 0, 0, 1);
      checkSlot("reset", 0, 0);
      checkOutput("reset.ce", {31'h0, rom_ce}, 0);
      checkOutput("reset.addr", rom_addr, 32'h0);

      // T1: zero-wait ROM, one instruction per cycle after BOOT
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("t1.boot.ce", {31'h0, rom_ce}, 1);
      checkOutput("t1.boot.addr", rom_addr, 32'h0);
      checkOutput("t1.boot.valid", {31'h0, valid_o}, 0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 0, 0, 1);
         checkSlot("t1.seq", 32'(i * 4), 1);
      end

      // T2: response every third cycle, two bubbles between instructions
      for (int k = 0; k < 2; k++) begin
         applyStimulus(0, 0, 0, 0, 0);
         checkSlot("t2.bubble1", 0, 0);
         checkOutput("t2.addr1", rom_addr, 32'h10 + 32'(k * 4));
         applyStimulus(0, 0, 0, 0, 0);
         checkSlot("t2.bubble2", 0, 0);
         checkOutput("t2.addr2", rom_addr, 32'h10 + 32'(k * 4));
         applyStimulus(0, 0, 0, 0, 1);
         checkSlot("t2.inst", 32'h10 + 32'(k * 4), 1);
      end

      // T3: stall while the response for 0x18 arrives, four cycles total
      applyStimulus(0, 1, 0, 0, 1);
      checkSlot("t3.frozen", 32'h14, 1);
      checkOutput("t3.ce", {31'h0, rom_ce}, 0);
      checkOutput("t3.addr", rom_addr, 32'h1C);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 1, 0, 0, 1);
         checkSlot("t3.held", 32'h14, 1);
         checkOutput("t3.held.ce", {31'h0, rom_ce}, 0);
      end
      applyStimulus(0, 0, 0, 0, 1);
      checkSlot("t3.release", 32'h18, 1);
      checkOutput("t3.release.ce", {31'h0, rom_ce}, 1);
      applyStimulus(0, 0, 0, 0, 1);
      checkSlot("t3.next", 32'h1C, 1);

      // T4: redirect to 0x100 while the request for 0x20 is pending
      applyStimulus(0, 0, 1, 32'h100, 0);
      checkSlot("t4.redir", 0, 0);
      checkOutput("t4.drain.addr", rom_addr, 32'h20);
      checkOutput("t4.drain.ce", {31'h0, rom_ce}, 1);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("t4.drain.addr2", rom_addr, 32'h20);
      checkSlot("t4.drain.bubble", 0, 0);
      applyStimulus(0, 0, 0, 0, 1);
      checkSlot("t4.discard", 0, 0);
      checkOutput("t4.target.addr", rom_addr, 32'h100);
      applyStimulus(0, 0, 0, 0, 1);
      checkSlot("t4.target", 32'h100, 1);
      applyStimulus(0, 0, 1, 32'h103, 1);
      checkSlot("t4.redir2", 0, 0);
      checkOutput("t4.align.addr", rom_addr, 32'h100);
      applyStimulus(0, 0, 0, 0, 1);
      checkSlot("t4.align", 32'h100, 1);

      // T5: redirect with stall held while in HOLD
      applyStimulus(0, 1, 0, 0, 1);
      checkOutput("t5.hold.ce", {31'h0, rom_ce}, 0);
      checkSlot("t5.hold", 32'h100, 1);
      applyStimulus(0, 1, 1, 32'h200, 0);
      checkSlot("t5.flush", 0, 0);
      checkOutput("t5.addr", rom_addr, 32'h200);
      checkOutput("t5.ce", {31'h0, rom_ce}, 1);
      applyStimulus(0, 0, 0, 0, 1);
      checkSlot("t5.target", 32'h200, 1);

      // T6: reset while a request is waiting
      applyStimulus(0, 0, 0, 0, 0);
      checkSlot("t6.wait", 0, 0);
      applyStimulus(1, 0, 0, 0, 1);
      checkSlot("t6.rst1", 0, 0);
      checkOutput("t6.rst1.ce", {31'h0, rom_ce}, 0);
      checkOutput("t6.rst1.addr", rom_addr, 32'h0);
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 1);
      checkSlot("t6.refetch1", 32'h0, 1);

      // T6: reset while in HOLD
      applyStimulus(0, 1, 0, 0, 1);
      checkOutput("t6.hold.ce", {31'h0, rom_ce}, 0);
      applyStimulus(1, 1, 0, 0, 1);
      checkSlot("t6.rst2", 0, 0);
      checkOutput("t6.rst2.ce", {31'h0, rom_ce}, 0);
      checkOutput("t6.rst2.addr", rom_addr, 32'h0);
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 1);
      checkSlot("t6.refetch2", 32'h0, 1);

      // T6: PC wraps from the top of the address space to zero
      applyStimulus(0, 0, 1, 32'hFFFF_FFFC, 1);
      checkSlot("t6.wrap.redir", 0, 0);
      checkOutput("t6.wrap.addr0", rom_addr, 32'hFFFF_FFFC);
      applyStimulus(0, 0, 0, 0, 1);
      checkSlot("t6.wrap.top", 32'hFFFF_FFFC, 1);
      checkOutput("t6.wrap.addr1", rom_addr, 32'h0);
      applyStimulus(0, 0, 0, 0, 1);
      checkSlot("t6.wrap.zero", 32'h0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
